receiver_uart: RTL and testbench

Byte-oriented UART receiver: the receive counterpart of `corescore_emitter_uart` on the SOC's FTDI link. It samples `ftdi_rxd` (8N1, LSB first), assembles bytes and buffers them for the CPU. A valid/ready port presents each byte, and per-event pulses flag framing and overrun errors. The SOC maps it into the IO page next to the UART data/control words.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/receiver_uart_if.sv | 19 +
 rtl/receiver_uart_fifo.sv | 90 +++++++++
 rtl/receiver_uart.sv | 215 +++++++++++++++++++++
 tb/tb_receiver_uart.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path.
//   - rx_state_e      : receiver FSM state encoding
//   - UART_DATA_BITS  : data bits per frame (8N1)
//   - RX_FIFO_DEPTH   : entries in the optional receive FIFO
//   - calc_bit_cycles : clock cycles per bit period
// ---------------------------------------------------------------------------
package uart_pkg;

   localparam int UART_DATA_BITS = 8;
   localparam int RX_FIFO_DEPTH  = 4;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_STOP      = 3'd3,
      ST_WAIT_HIGH = 3'd4
   } rx_state_e;

   // Integer division: the bit period is rounded down.
   function automatic int calc_bit_cycles(input int clk_freq_hz, input int baud_rate);
      return clk_freq_hz / baud_rate;
   endfunction

endpackage

// File: rtl/receiver_uart_if.sv
// ---------------------------------------------------------------------------
// receiver_uart_if
// Byte stream from the UART receiver to its consumer.
//   o_data  : head-of-buffer byte, meaningful only while o_valid = 1
//   o_valid : at least one byte is buffered
//   i_ready : consumer takes the head byte (pop on o_valid & i_ready)
// Modports: master = receiver side, slave = consumer side.
// ---------------------------------------------------------------------------
interface receiver_uart_if;
   import uart_pkg::*;

   logic [UART_DATA_BITS-1:0] o_data;
   logic                      o_valid;
   logic                      i_ready;

   modport master (output o_data, output o_valid, input i_ready);
   modport slave  (input o_data, input o_valid, output i_ready);

endinterface

// File: rtl/receiver_uart_fifo.sv
// ---------------------------------------------------------------------------
// rx_fifo
// Small circular receive FIFO with a valid/ready pop side and push/full
// on the write side. A push into a full FIFO is accepted only when a pop
// happens in the same cycle; otherwise the caller reports the overrun.
// Ports:
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_push         : write request, i_push_data is the byte
//   o_full         : count == DEPTH
//   o_data/o_valid : head entry and non-empty flag (from registers)
//   i_ready        : consumer pops the head entry
// ---------------------------------------------------------------------------
module rx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   output logic             o_full,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   input  logic             i_ready
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [DEPTH-1:0] entry_we;
   logic             pop;
   logic             wr_en;

   assign o_full  = (count_q == CNT_W'(DEPTH));
   assign o_valid = (count_q != '0);
   assign o_data  = mem_q[rd_ptr_q];

   assign pop   = o_valid & i_ready;
   // When full, the slot being written is the one being popped this cycle.
   assign wr_en = i_push & (~o_full | pop);

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_we
         assign entry_we[gi] = wr_en && (wr_ptr_q == PTR_W'(gi));
      end
   endgenerate

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) begin
         wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({wr_en, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         for (int i = 0; i < DEPTH; i++) begin
            if (entry_we[i]) begin
               mem_q[i] <= i_push_data;
            end
         end
      end
   end

endmodule

// File: rtl/receiver_uart.sv
// ---------------------------------------------------------------------------
// receiver_uart
// 8N1 UART receiver (LSB first) feeding a small byte buffer for the CPU.
// Build option: define RX_FIFO_EN for a 4-entry FIFO; otherwise a single
// holding register is used (full whenever o_valid = 1).
// Ports:
//   i_clk, i_rst : system clock, synchronous active-high reset
//   i_uart_rx    : raw asynchronous serial line, idle high
//   rx_bus       : receiver_uart_if.master (o_data / o_valid / i_ready)
//   o_busy       : a frame is being received (START/DATA/STOP)
//   o_frame_err  : one-cycle pulse, stop bit sampled low
//   o_overrun    : one-cycle pulse, completed byte dropped (buffer full)
// ---------------------------------------------------------------------------
module receiver_uart
   import uart_pkg::*;
#(
   parameter int clk_freq_hz = 25000000,
   parameter int baud_rate   = 115200
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_uart_rx,
   receiver_uart_if.master rx_bus,
   output logic            o_busy,
   output logic            o_frame_err,
   output logic            o_overrun
);

   localparam int BIT_CYCLES = calc_bit_cycles(clk_freq_hz, baud_rate);
   localparam int CNT_W      = $clog2(BIT_CYCLES);
   localparam int IDX_W      = $clog2(UART_DATA_BITS);

   // First sample lands mid start bit; later samples are one period apart.
   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BIT_CYCLES / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BIT_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(UART_DATA_BITS - 1);

   // Two-flop synchronizer, reset to the idle (high) line level.
   logic [1:0] sync_q;
   logic       rx_s;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], i_uart_rx};
      end
   end

   assign rx_s = sync_q[1];

   rx_state_e                 state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [IDX_W-1:0]          bit_idx_q, bit_idx_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;
   logic                      cnt_zero;
   logic                      push;
   logic                      frame_err_d, frame_err_q;
   logic                      overrun_d, overrun_q;
   logic                      busy;

   assign cnt_zero = (cnt_q == '0);

   // FSM state register (with its datapath registers)
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
      end
   end

   // FSM next state
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      case (state_q)
         ST_IDLE: begin
            if (!rx_s) begin
               cnt_d   = HALF_LOAD;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (cnt_zero) begin
               if (!rx_s) begin
                  cnt_d     = FULL_LOAD;
                  bit_idx_d = '0;
                  state_d   = ST_DATA;
               end else begin
                  // Start bit gone by mid-bit: treat as a glitch.
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_DATA: begin
            if (cnt_zero) begin
               // Right shift: the first (LSB) bit ends up in bit 0.
               shift_d   = {rx_s, shift_q[UART_DATA_BITS-1:1]};
               cnt_d     = FULL_LOAD;
               bit_idx_d = bit_idx_q + 1'b1;
               if (bit_idx_q == LAST_BIT) begin
                  state_d = ST_STOP;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_STOP: begin
            if (cnt_zero) begin
               state_d = rx_s ? ST_IDLE : ST_WAIT_HIGH;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_WAIT_HIGH: begin
            // A held-low break reports once, then waits for the line to idle.
            if (rx_s) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy        = 1'b0;
      push        = 1'b0;
      frame_err_d = 1'b0;
      case (state_q)
         ST_START, ST_DATA: busy = 1'b1;
         ST_STOP: begin
            busy        = 1'b1;
            push        = cnt_zero & rx_s;
            frame_err_d = cnt_zero & ~rx_s;
         end
         default: busy = 1'b0;
      endcase
   end

   assign o_busy = busy;

   // Byte buffer
   logic                      buf_full;
   logic                      buf_valid;
   logic [UART_DATA_BITS-1:0] buf_data;
   logic                      pop;

`ifdef RX_FIFO_EN
   rx_fifo #(
      .DEPTH (RX_FIFO_DEPTH),
      .WIDTH (UART_DATA_BITS)
   ) u_rx_fifo (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_push      (push),
      .i_push_data (shift_q),
      .o_full      (buf_full),
      .o_data      (buf_data),
      .o_valid     (buf_valid),
      .i_ready     (rx_bus.i_ready)
   );
`else
   logic [UART_DATA_BITS-1:0] hold_data_q;
   logic                      hold_valid_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         hold_data_q  <= '0;
         hold_valid_q <= 1'b0;
      end else if (push && (!hold_valid_q || pop)) begin
         hold_data_q  <= shift_q;
         hold_valid_q <= 1'b1;
      end else if (pop) begin
         hold_valid_q <= 1'b0;
      end
   end

   assign buf_full  = hold_valid_q;
   assign buf_valid = hold_valid_q;
   assign buf_data  = hold_data_q;
`endif

   assign pop            = buf_valid & rx_bus.i_ready;
   assign rx_bus.o_valid = buf_valid;
   assign rx_bus.o_data  = buf_data;

   // A pop in the same cycle frees the slot, so only push-while-full-without-pop drops.
   assign overrun_d = push & buf_full & ~pop;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign o_frame_err = frame_err_q;
   assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_receiver_uart.sv
// ---------------------------------------------------------------------------
// tb_receiver_uart
// Self-checking bench for receiver_uart. Serial frames are generated bit by
// bit; expected bytes, error counts and overrun counts come from a simple
// buffer-capacity model (DEPTH = 4 with RX_FIFO_EN, else 1).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_receiver_uart;
   import uart_pkg::*;

   localparam int CLK_HZ = 25000000;
   localparam int BAUD   = 115200;
   localparam int BITC   = CLK_HZ / BAUD;
`ifdef RX_FIFO_EN
   localparam int DEPTH = RX_FIFO_DEPTH;
`else
   localparam int DEPTH = 1;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rx  = 1'b1;
   logic busy, fe, ov;

   receiver_uart_if bus ();

   receiver_uart #(
      .clk_freq_hz (CLK_HZ),
      .baud_rate   (BAUD)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_uart_rx   (rx),
      .rx_bus      (bus),
      .o_busy      (busy),
      .o_frame_err (fe),
      .o_overrun   (ov)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_bad  = 0;
   int fe_cnt = 0;
   int ov_cnt = 0;
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];

   // Pop recorder and error-pulse counters
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.o_valid && bus.i_ready) got_q.push_back(bus.o_data);
         if (fe) fe_cnt++;
         if (ov) ov_cnt++;
      end
   end

   task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, req);
      end
   endtask

   // Advance n rising edges, then step 1ns past the edge.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_v, input int stop_len, input int gap);
      $display("tx frame data=0x%02h stop=%0b", d, stop_v);
      rx = 1'b0;
      tick(BITC);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         tick(BITC);
      end
      rx = stop_v;
      tick(stop_len);
      rx = 1'b1;
      if (gap > 0) tick(gap);
   endtask

   task automatic compare_queues(input string tag);
      int n;
      check_value({tag, "_count"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         $display("rx byte %s[%0d] = 0x%02h (model 0x%02h)", tag, i, got_q[i], exp_q[i]);
         check_value({tag, "_byte"}, {24'd0, got_q[i]}, {24'd0, exp_q[i]});
      end
      got_q.delete();
      exp_q.delete();
   endtask

   // Pop one byte per cycle-pulse of i_ready; buffer must hold exactly n.
   task automatic drain_step(input int n);
      for (int i = 0; i < n; i++) begin
         check_value("drain_valid", {31'd0, bus.o_valid}, 32'd1);
         bus.i_ready = 1'b1;
         tick(1);
         bus.i_ready = 1'b0;
      end
      check_value("drain_empty", {31'd0, bus.o_valid}, 32'd0);
   endtask

   initial begin
      int fe0, ov0, nb, n, exp_ov;
      logic [7:0] d;
      logic ok;

      bus.i_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_value("rst_valid", {31'd0, bus.o_valid}, 32'd0);
      check_value("rst_data",  {24'd0, bus.o_data}, 32'd0);
      check_value("rst_busy",  {31'd0, busy}, 32'd0);
      check_value("rst_ferr",  {31'd0, fe}, 32'd0);
      check_value("rst_ovr",   {31'd0, ov}, 32'd0);
      rst = 1'b0;
      tick(10);

      // Single frame 0xA5, consumer ready: exact timing relative to S
      fe0 = fe_cnt; ov0 = ov_cnt;
      bus.i_ready = 1'b1;
      fork
         send_frame(8'hA5, 1'b1, BITC, 20);
         begin
            tick(1002);
            check_value("a5_busy_mid", {31'd0, busy}, 32'd1);
            tick(1061);
            check_value("a5_valid_early", {31'd0, bus.o_valid}, 32'd0);
            tick(1);
            check_value("a5_valid_on_time", {31'd0, bus.o_valid}, 32'd1);
            check_value("a5_data", {24'd0, bus.o_data}, 32'hA5);
            tick(1);
            check_value("a5_popped", {31'd0, bus.o_valid}, 32'd0);
         end
      join
      exp_q.push_back(8'hA5);
      compare_queues("a5");
      check_value("a5_ferr", fe_cnt - fe0, 0);
      check_value("a5_ovr", ov_cnt - ov0, 0);

      // Glitch: 50 low cycles
      fe0 = fe_cnt;
      rx = 1'b0;
      tick(50);
      rx = 1'b1;
      tick(300);
      $display("glitch done");
      check_value("glitch_busy", {31'd0, busy}, 32'd0);
      check_value("glitch_valid", {31'd0, bus.o_valid}, 32'd0);
      check_value("glitch_ferr", fe_cnt - fe0, 0);

      // Break: bad stop bit on 0x3C, line held low 5000 cycles, then 0x11
      fe0 = fe_cnt;
      send_frame(8'h3C, 1'b0, 5000, 300);
      check_value("break_ferr", fe_cnt - fe0, 1);
      compare_queues("break");
      send_frame(8'h11, 1'b1, BITC, 20);
      exp_q.push_back(8'h11);
      compare_queues("after_break");

      // Stalled consumer, 0x01..0x05 back to back
      bus.i_ready = 1'b0;
      ov0 = ov_cnt;
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, BITC, 0);
      tick(5);
      for (int i = 1; i <= DEPTH; i++) exp_q.push_back(8'(i));
      check_value("stall_ovr", ov_cnt - ov0, 5 - DEPTH);
      drain_step(DEPTH);
      compare_queues("stall");

      // Full buffer, pop coincides with the stop-bit push
      ov0 = ov_cnt;
      for (int i = 0; i < DEPTH; i++) begin
         d = 8'($urandom_range(0, 255));
         exp_q.push_back(d);
         send_frame(d, 1'b1, BITC, 0);
      end
      check_value("full_valid", {31'd0, bus.o_valid}, 32'd1);
      d = 8'($urandom_range(0, 255));
      fork
         send_frame(d, 1'b1, BITC, 0);
         begin
            tick(2063);
            bus.i_ready = 1'b1;
            tick(1);
            bus.i_ready = 1'b0;
         end
      join
      exp_q.push_back(d);
      tick(5);
      check_value("fullpop_ovr", ov_cnt - ov0, 0);
      drain_step(DEPTH);
      compare_queues("fullpop");

      // Reset mid-frame with 2 bytes buffered, then 0x7E
      ov0 = ov_cnt;
      send_frame(8'h5A, 1'b1, BITC, 0);
      send_frame(8'hC3, 1'b1, BITC, 0);
      exp_ov = (2 > DEPTH) ? 2 - DEPTH : 0;
      check_value("prerst_ovr", ov_cnt - ov0, exp_ov);
      check_value("prerst_valid", {31'd0, bus.o_valid}, 32'd1);
      rx = 1'b0;
      tick(1002);
      rst = 1'b1;
      rx  = 1'b1;
      tick(1);
      check_value("midrst_valid", {31'd0, bus.o_valid}, 32'd0);
      check_value("midrst_data",  {24'd0, bus.o_data}, 32'd0);
      check_value("midrst_busy",  {31'd0, busy}, 32'd0);
      check_value("midrst_ferr",  {31'd0, fe}, 32'd0);
      check_value("midrst_ovr",   {31'd0, ov}, 32'd0);
      rst = 1'b0;
      tick(300);
      compare_queues("midrst");
      bus.i_ready = 1'b1;
      send_frame(8'h7E, 1'b1, BITC, 20);
      exp_q.push_back(8'h7E);
      compare_queues("after_rst");

      // Random frames, consumer ready, some with a bad stop bit
      fe0 = fe_cnt; nb = 0;
      for (int i = 0; i < 4; i++) begin
         d  = 8'($urandom_range(0, 255));
         ok = ($urandom_range(0, 3) != 0);
         send_frame(d, ok, BITC, $urandom_range(2, 30));
         if (ok) exp_q.push_back(d);
         else    nb++;
      end
      tick(10);
      check_value("rand_ferr", fe_cnt - fe0, nb);
      compare_queues("rand_ready");

      // Random stalled burst
      bus.i_ready = 1'b0;
      ov0 = ov_cnt;
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
         d = 8'($urandom_range(0, 255));
         if (i < DEPTH) exp_q.push_back(d);
         send_frame(d, 1'b1, BITC, 0);
      end
      tick(5);
      check_value("rand_ovr", ov_cnt - ov0, (n > DEPTH) ? n - DEPTH : 0);
      drain_step((n < DEPTH) ? n : DEPTH);
      compare_queues("rand_stall");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
